// File: rtl/alu_pkg.sv
// Shared ALU op / opcode / funct constants and the issue-queue entry record.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [2:0]       op;
    logic             illegal;
  } alu_entry_t;

  // Builds a recognised (non-illegal) entry from its operands and op.
  function automatic alu_entry_t legal_entry(input logic [ALU_W-1:0] a,
                                             input logic [ALU_W-1:0] b,
                                             input logic [2:0]       op);
    alu_entry_t e;
    e.a       = a;
    e.b       = b;
    e.op      = op;
    e.illegal = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of opcode/funct/register/immediate fields into an ALU issue entry.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the entry is captured.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [ALU_W-1:0] rs,
  input  logic [ALU_W-1:0] rt,
  input  logic [15:0]      imm,
  output alu_entry_t       entry
);

  logic [ALU_W-1:0] imm_sext;
  logic [ALU_W-1:0] imm_zext;

  assign imm_sext = {{(ALU_W-16){imm[15]}}, imm};
  assign imm_zext = {{(ALU_W-16){1'b0}}, imm};

  // Map the encoding to operands and op; anything unrecognised becomes a zeroed illegal entry.
  always_comb begin
    entry         = '0;
    entry.illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_AND:  entry = legal_entry(rs, rt, ALU_AND);
          FN_OR:   entry = legal_entry(rs, rt, ALU_OR);
          FN_ADD:  entry = legal_entry(rs, rt, ALU_ADD);
          FN_SUB:  entry = legal_entry(rs, rt, ALU_SUB);
          FN_SLT:  entry = legal_entry(rs, rt, ALU_SLT);
          default: ;
        endcase
      end
      OP_ADDI: entry = legal_entry(rs, imm_sext, ALU_ADD);
      OP_ANDI: entry = legal_entry(rs, imm_zext, ALU_AND);
      OP_ORI:  entry = legal_entry(rs, imm_zext, ALU_OR);
      OP_SLTI: entry = legal_entry(rs, imm_sext, ALU_SLT);
      OP_LW,
      OP_SW:   entry = legal_entry(rs, imm_sext, ALU_ADD);
      OP_BEQ:  entry = legal_entry(rs, rt, ALU_SUB);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage: decodes instruction fields into ALU operands/op and queues them for yAlu.
// Latency: 1 cycle from accept to out_valid when empty; 1 entry/cycle sustained.
// Backpressure: in_ready = not full (registered state only); head holds while out_ready is low.
module alu_issue
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,  // must equal ALU_W: entries carry ALU_W-wide operands
  parameter int DEPTH = 2       // power of two, >= 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   in_opcode,
  input  logic [5:0]   in_funct,
  input  logic [W-1:0] in_rs,
  input  logic [W-1:0] in_rt,
  input  logic [15:0]  in_imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [2:0]   out_op,
  output logic         out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  alu_entry_t    dec_entry;
  alu_entry_t    head;
  alu_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  alu_decode u_decode (
    .opcode (in_opcode),
    .funct  (in_funct),
    .rs     (in_rs),
    .rt     (in_rt),
    .imm    (in_imm),
    .entry  (dec_entry)
  );

  assign in_ready  = (count < CNT_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry, forced to zero when the queue is empty so stale slots never leak out.
  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_a       = head.a;
  assign out_b       = head.b;
  assign out_op      = head.op;
  assign out_illegal = head.illegal;

  // Queue storage and pointers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_entry;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: decode table through a scoreboard plus stall/stream/reset sequences.
// Latency: checks 1-cycle accept-to-output and 1/cycle streaming.
// Backpressure: exercises full-queue stall and drain ordering.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_opcode;
  logic [5:0]   in_funct;
  logic [W-1:0] in_rs;
  logic [W-1:0] in_rt;
  logic [15:0]  in_imm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [2:0]   out_op;
  logic         out_illegal;

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [2:0]  eop;
    logic        eill;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ill;
  } exp_t;

  vec_t tbl [15];
  exp_t sb [$];
  exp_t cur_exp;
  int   tests = 0;
  int   fails = 0;

  alu_issue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct    (in_funct),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_op      (out_op),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] opc, input logic [5:0] fn,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [15:0] imm, input logic [31:0] ea,
                              input logic [31:0] eb, input logic [2:0] eop,
                              input logic eill);
    vec_t v;
    v.opc = opc; v.fn = fn; v.rs = rs; v.rt = rt; v.imm = imm;
    v.ea = ea; v.eb = eb; v.eop = eop; v.eill = eill;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    in_valid  = 1'b1;
    in_opcode = v.opc;
    in_funct  = v.fn;
    in_rs     = v.rs;
    in_rt     = v.rt;
    in_imm    = v.imm;
    cur_exp   = '{a: v.ea, b: v.eb, op: v.eop, ill: v.eill};
  endtask

  // Present v and return at #1 after the edge that accepted it; in_valid is left high.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    set_in(v);
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_opcode = 'x;
    in_funct  = 'x;
    in_rs     = 'x;
    in_rt     = 'x;
    in_imm    = 'x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: compare on every output handshake, record every input handshake, flush on reset.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: a=%h b=%h op=%b ill=%b, required no output",
                   out_a, out_b, out_op, out_illegal);
        end else begin
          e = sb.pop_front();
          check("sb_a",   out_a, e.a);
          check("sb_b",   out_b, e.b);
          check("sb_op",  32'(out_op), 32'(e.op));
          check("sb_ill", 32'(out_illegal), 32'(e.ill));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(6'h00, 6'h20, 32'd5,      32'd7,         16'h1234, 32'd5,      32'd7,         3'b010, 1'b0);
    tbl[1]  = mk(6'h08, 6'h00, 32'd10,     32'hDEADBEEF,  16'hFFFF, 32'd10,     32'hFFFFFFFF,  3'b010, 1'b0);
    tbl[2]  = mk(6'h0C, 6'h00, 32'd3,      32'hDEADBEEF,  16'hFFFF, 32'd3,      32'h0000FFFF,  3'b000, 1'b0);
    tbl[3]  = mk(6'h0A, 6'h00, 32'd1,      32'hDEADBEEF,  16'h8000, 32'd1,      32'hFFFF8000,  3'b111, 1'b0);
    tbl[4]  = mk(6'h0D, 6'h3F, 32'd2,      32'hDEADBEEF,  16'h8001, 32'd2,      32'h00008001,  3'b001, 1'b0);
    tbl[5]  = mk(6'h23, 6'h00, 32'd100,    32'd77,        16'h0010, 32'd100,    32'h00000010,  3'b010, 1'b0);
    tbl[6]  = mk(6'h2B, 6'h00, 32'd200,    32'd77,        16'hFFFC, 32'd200,    32'hFFFFFFFC,  3'b010, 1'b0);
    tbl[7]  = mk(6'h04, 6'h00, 32'd9,      32'd9,         16'h0003, 32'd9,      32'd9,         3'b110, 1'b0);
    tbl[8]  = mk(6'h00, 6'h24, 32'hF0F0,   32'h0FF0,      16'h0000, 32'hF0F0,   32'h0FF0,      3'b000, 1'b0);
    tbl[9]  = mk(6'h00, 6'h25, 32'h1111,   32'h2222,      16'h0005, 32'h1111,   32'h2222,      3'b001, 1'b0);
    tbl[10] = mk(6'h00, 6'h22, 32'd50,     32'd8,         16'hFFFF, 32'd50,     32'd8,         3'b110, 1'b0);
    tbl[11] = mk(6'h00, 6'h2A, 32'd3,      32'd4,         16'h0000, 32'd3,      32'd4,         3'b111, 1'b0);
    tbl[12] = mk(6'h3F, 6'h20, 32'd1,      32'd2,         16'hFFFF, 32'd0,      32'd0,         3'b000, 1'b1);
    tbl[13] = mk(6'h00, 6'h03, 32'd6,      32'd7,         16'h0001, 32'd0,      32'd0,         3'b000, 1'b1);
    tbl[14] = mk(6'h08, 6'h00, 32'd4,      32'd0,         16'h7FFF, 32'd4,      32'h00007FFF,  3'b010, 1'b0);

    // Reset state.
    reset = 1'b1;
    out_ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_a",     out_a, 32'd0);
    check("rst_out_b",     out_b, 32'd0);
    check("rst_out_op",    32'(out_op), 32'd0);
    check("rst_out_ill",   32'(out_illegal), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);

    // First-transaction latency: visible the cycle after the accepting edge.
    out_ready = 1'b1;
    send(tbl[0]);
    idle();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_a",     out_a, 32'd5);
    check("lat_b",     out_b, 32'd7);
    check("lat_op",    32'(out_op), 32'(3'b010));
    check("lat_ill",   32'(out_illegal), 32'd0);
    check("lat_alu_z", out_a + out_b, 32'd12);
    drain();

    // Full decode table streamed through the scoreboard.
    for (int i = 0; i < 15; i++) begin
      send(tbl[i]);
    end
    idle();
    drain();

    // Full-rate streaming: sub/or/slt/beq twice.
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: send(tbl[10]);
        1: send(tbl[9]);
        2: send(tbl[11]);
        default: send(tbl[7]);
      endcase
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_ready", 32'(in_ready), 32'd1);
    end
    idle();
    drain();

    // Backpressure: two accepted, third held, head stable.
    out_ready = 1'b0;
    send(tbl[1]);
    check("bp_ready_after1", 32'(in_ready), 32'd1);
    send(tbl[2]);
    check("bp_ready_after2", 32'(in_ready), 32'd0);
    set_in(tbl[3]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_a",     out_a, 32'd10);
      check("bp_hold_b",     out_b, 32'hFFFFFFFF);
      check("bp_hold_op",    32'(out_op), 32'(3'b010));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(tbl[3]);
    idle();
    drain();

    // Reset with two entries pending and a valid input at the reset edge.
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[8]);
    set_in(tbl[12]);
    out_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_a",     out_a, 32'd0);
    check("flush_b",     out_b, 32'd0);
    check("flush_op",    32'(out_op), 32'd0);
    check("flush_ill",   32'(out_illegal), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("flush_no_enq", 32'(out_valid), 32'd0);

    // Reset with one entry pending while both a push and a pop would otherwise happen.
    out_ready = 1'b0;
    send(tbl[5]);
    set_in(tbl[6]);
    out_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    check("flush1_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("flush1_no_enq", 32'(out_valid), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
